// File: rtl/fp_simd_vec.sv
// Lane-parallel custom-float SIMD unit: ADD/SUB/MUL/MIN/MAX per lane, plus RADD/DOT folded
// across lanes over log2(LANES) reduce steps. One op in flight; result held until consumed.

module fp_simd_lane #(
  parameter int EXP_W = 7,
  parameter int MAN_W = 14
) (
  input  logic [2:0]           op,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic [EXP_W+MAN_W:0] r,
  output logic                 ovf
);
  localparam int FW   = 1 + EXP_W + MAN_W;
  localparam int MAGW = EXP_W + MAN_W;
  localparam int G    = 3;
  localparam int MW   = MAN_W + 1 + G;
  localparam int EW   = EXP_W + 3;
  localparam int LZW  = $clog2(MW);
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int EMAX = 2**EXP_W - 1;

  logic [MAGW-1:0]        mag_a, mag_b, mag_big, mag_sm;
  logic                   sb_eff, swap, s_big, s_sm;
  logic [EXP_W-1:0]       e_big, e_sm, d;
  logic [MW-1:0]          m_big, m_sm, m_sh, norm;
  logic [MW:0]            sum;
  logic [LZW-1:0]         lz;
  logic signed [EW-1:0]   e_add, e_mul;
  logic [2*MAN_W+1:0]     ma_x, mb_x, prod;
  logic [MAN_W-1:0]       f_mul;
  logic signed [MAGW:0]   key_a, key_b;
  logic [FW-1:0]          r_add, r_mul, r_mm;
  logic                   ovf_add, ovf_mul;
  logic                   unused_bits;

  // {ovf, result}: zero/underflow -> +0, exponent overflow -> saturate with flag
  function automatic logic [FW:0] pack(input logic s, input logic signed [EW-1:0] e,
                                       input logic [MAN_W-1:0] f, input logic z);
    if (z || e[EW-1] || e == '0) return '0;
    else if (e[EW-2:0] > (EW-1)'(EMAX)) return {1'b1, s, {MAGW{1'b1}}};
    else return {1'b0, s, e[EXP_W-1:0], f};
  endfunction

  always_comb begin
    mag_a   = (a[MAGW-1:MAN_W] == '0) ? '0 : a[MAGW-1:0];
    mag_b   = (b[MAGW-1:MAN_W] == '0) ? '0 : b[MAGW-1:0];
    sb_eff  = (op == 3'd1) ? ~b[FW-1] : b[FW-1];
    swap    = mag_b > mag_a;
    mag_big = swap ? mag_b : mag_a;
    mag_sm  = swap ? mag_a : mag_b;
    s_big   = swap ? sb_eff : a[FW-1];
    s_sm    = swap ? a[FW-1] : sb_eff;
    e_big   = mag_big[MAGW-1:MAN_W];
    e_sm    = mag_sm[MAGW-1:MAN_W];
    m_big   = (e_big == '0) ? '0 : {1'b1, mag_big[MAN_W-1:0], {G{1'b0}}};
    m_sm    = (e_sm == '0) ? '0 : {1'b1, mag_sm[MAN_W-1:0], {G{1'b0}}};
    d       = e_big - e_sm;
    m_sh    = (int'(d) >= MW) ? '0 : (m_sm >> d);
    lz      = '0;
    if (s_big == s_sm) sum = {1'b0, m_big} + {1'b0, m_sh};
    else               sum = {1'b0, m_big} - {1'b0, m_sh};
    e_add = $signed({{(EW-EXP_W){1'b0}}, e_big});
    if (sum[MW]) begin
      norm  = sum[MW:1];
      e_add = e_add + EW'(1);
    end else begin
      for (int k = 0; k < MW; k++) if (sum[k]) lz = LZW'(MW-1-k);
      norm  = sum[MW-1:0] << lz;
      e_add = e_add - $signed({{(EW-LZW){1'b0}}, lz});
    end
    {ovf_add, r_add} = pack(s_big, e_add, norm[MW-2 -: MAN_W], ~norm[MW-1]);

    ma_x  = {{(MAN_W+1){1'b0}}, 1'b1, a[MAN_W-1:0]};
    mb_x  = {{(MAN_W+1){1'b0}}, 1'b1, b[MAN_W-1:0]};
    prod  = ma_x * mb_x;
    e_mul = $signed({{(EW-EXP_W){1'b0}}, a[MAGW-1:MAN_W]})
          + $signed({{(EW-EXP_W){1'b0}}, b[MAGW-1:MAN_W]}) - EW'(BIAS);
    if (prod[2*MAN_W+1]) begin
      f_mul = prod[2*MAN_W -: MAN_W];
      e_mul = e_mul + EW'(1);
    end else begin
      f_mul = prod[2*MAN_W-1 -: MAN_W];
    end
    {ovf_mul, r_mul} = pack(a[FW-1] ^ b[FW-1], e_mul, f_mul, (mag_a == '0) || (mag_b == '0));

    // signed-magnitude to two's complement so -0 and +0 compare equal
    key_a = $signed({1'b0, mag_a});
    if (a[FW-1] && mag_a != '0) key_a = -key_a;
    key_b = $signed({1'b0, mag_b});
    if (b[FW-1] && mag_b != '0) key_b = -key_b;
    if (op == 3'd5) r_mm = (key_b < key_a) ? b : a;
    else            r_mm = (key_b > key_a) ? b : a;
    if (r_mm[MAGW-1:MAN_W] == '0) r_mm = '0;

    r   = '0;
    ovf = 1'b0;
    case (op)
      3'd0, 3'd1: begin r = r_add; ovf = ovf_add; end
      3'd2, 3'd4: begin r = r_mul; ovf = ovf_mul; end
      3'd3:       r = a;
      3'd5, 3'd6: r = r_mm;
      default:    ;
    endcase
  end

  assign unused_bits = ^{prod[MAN_W-2:0], norm[G-1:0]};
endmodule

module fp_simd_vec #(
  parameter int LANES = 4,
  parameter int EXP_W = 7,
  parameter int MAN_W = 14
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_en,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] i_in1,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] i_in2,
  input  logic [2:0]                       i_opcode,
  input  logic                             i_rdy,
  output logic [LANES*(1+EXP_W+MAN_W)-1:0] o_output,
  output logic                             o_valid,
  output logic                             o_busy,
  output logic [LANES-1:0]                 o_ovf
);
  localparam int FW = 1 + EXP_W + MAN_W;
  localparam int SW = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, EXEC, REDUCE, DONE} state_e;

  state_e                   state_q, state_d;
  logic [LANES-1:0][FW-1:0] a_q, a_d, b_q, b_d, res_q, res_d, la, lb, lr;
  logic [2:0]               op_q, op_d, lop;
  logic [LANES-1:0]         ovf_q, ovf_d, lovf;
  logic                     valid_q, valid_d;
  logic [SW-1:0]            stride_q, stride_d;

  // Slot LANES-1-i holds lane i, so lane 0 sits in the MSB slice.
  always_comb begin
    la  = a_q;
    lb  = b_q;
    lop = op_q;
    if (state_q == REDUCE) begin
      la  = res_q;
      lb  = '0;
      lop = 3'd0;
      for (int i = 0; i < LANES; i++)
        for (int j = 0; j < LANES; j++)
          if (i < int'(stride_q) && (j - i) == int'(stride_q)) lb[LANES-1-i] = res_q[LANES-1-j];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp_simd_lane #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_lane (
      .op(lop), .a(la[g]), .b(lb[g]), .r(lr[g]), .ovf(lovf[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    stride_d = stride_q;
    case (state_q)
      IDLE: if (i_en) begin
        a_d     = i_in1;
        b_d     = i_in2;
        op_d    = i_opcode;
        state_d = EXEC;
      end
      EXEC: begin
        res_d = lr;
        ovf_d = lovf;
        if (op_q == 3'd3 || op_q == 3'd4) begin
          stride_d = SW'(LANES/2);
          state_d  = REDUCE;
        end else begin
          state_d = DONE;
        end
      end
      REDUCE: begin
        for (int i = 0; i < LANES; i++) begin
          if (i < int'(stride_q)) begin
            res_d[LANES-1-i] = lr[LANES-1-i];
            ovf_d[LANES-1-i] = ovf_q[LANES-1-i] | lovf[LANES-1-i];
          end else begin
            res_d[LANES-1-i] = '0;
          end
        end
        stride_d = stride_q >> 1;
        if (stride_q == SW'(1)) state_d = DONE;
      end
      DONE:    if (i_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      ovf_q    <= '0;
      valid_q  <= 1'b0;
      stride_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      stride_q <= stride_d;
    end
  end

  assign o_output = res_q;
  assign o_valid  = valid_q;
  assign o_busy   = (state_q != IDLE);
  assign o_ovf    = ovf_q;
endmodule

// File: tb/tb_fp_simd_vec.sv
// Directed bench for fp_simd_vec: vector table of lane-wise/reduce ops plus
// busy, back-pressure and mid-reduce reset sequences.

module tb_fp_simd_vec;
  localparam int LANES = 4;
  localparam int FW    = 22;
  localparam int W     = LANES * FW;

  localparam logic [FW-1:0] ZERO   = 22'h000000;
  localparam logic [FW-1:0] HALF   = 22'h0F8000;
  localparam logic [FW-1:0] ONE    = 22'h0FC000;
  localparam logic [FW-1:0] ONE5   = 22'h0FE000;
  localparam logic [FW-1:0] TWO    = 22'h100000;
  localparam logic [FW-1:0] TWO5   = 22'h101000;
  localparam logic [FW-1:0] THREE  = 22'h102000;
  localparam logic [FW-1:0] THREE5 = 22'h103000;
  localparam logic [FW-1:0] FOUR   = 22'h104000;
  localparam logic [FW-1:0] TEN    = 22'h109000;
  localparam logic [FW-1:0] PMAX   = 22'h1FFFFF;
  localparam logic [FW-1:0] NMAX   = 22'h3FFFFF;

  logic             clk = 1'b0;
  logic             rst, i_en, i_rdy, o_valid, o_busy;
  logic [2:0]       i_opcode;
  logic [W-1:0]     i_in1, i_in2, o_output;
  logic [LANES-1:0] o_ovf;
  int               n_vec = 0;
  int               n_bad = 0;

  always #5 clk = ~clk;

  fp_simd_vec #(.LANES(LANES), .EXP_W(7), .MAN_W(14)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_in1(i_in1), .i_in2(i_in2), .i_opcode(i_opcode),
    .i_rdy(i_rdy), .o_output(o_output), .o_valid(o_valid), .o_busy(o_busy), .o_ovf(o_ovf)
  );

  typedef struct {
    logic [2:0]       op;
    logic [W-1:0]     a, b, y;
    logic [LANES-1:0] ovf;
    int               lat;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Issue one op with i_rdy=1; lat is the first negedge (1 = EXEC) at which o_valid is seen.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] y, output logic [LANES-1:0] ov, output int lat);
    @(negedge clk);
    i_en = 1'b1; i_opcode = op; i_in1 = a; i_in2 = b;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      i_en = 1'b0;
      if (o_valid) begin lat = c; break; end
    end
    y  = o_output;
    ov = o_ovf;
    @(posedge clk);
  endtask

  initial begin
    logic [W-1:0]     y;
    logic [LANES-1:0] ov;
    int               lat;
    logic             seen;

    tbl[0]  = '{3'd0, {ONE, TWO, TWO5, THREE}, {HALF, TWO, ONE, ONE}, {ONE5, FOUR, THREE5, FOUR}, 4'b0000, 2};
    tbl[1]  = '{3'd1, {ONE, TWO, TWO5, THREE}, {HALF, TWO, ONE, ONE}, {HALF, ZERO, ONE5, TWO}, 4'b0000, 2};
    tbl[2]  = '{3'd3, {HALF, ZERO, ONE5, TWO}, {4{ZERO}}, {FOUR, ZERO, ZERO, ZERO}, 4'b0000, 4};
    tbl[3]  = '{3'd2, {PMAX, ONE, TWO, ONE5}, {TWO, HALF, TWO, ONE5}, {PMAX, HALF, FOUR, 22'h100800}, 4'b1000, 2};
    tbl[4]  = '{3'd4, {ONE, TWO, TWO5, THREE}, {HALF, TWO, ONE, ONE}, {TEN, ZERO, ZERO, ZERO}, 4'b0000, 4};
    tbl[5]  = '{3'd5, {22'h2FC000, 22'h200000, THREE, TWO}, {HALF, ZERO, THREE5, 22'h300000},
                {22'h2FC000, ZERO, THREE, 22'h300000}, 4'b0000, 2};
    tbl[6]  = '{3'd6, {22'h2FC000, 22'h200000, THREE, TWO}, {HALF, ZERO, THREE5, 22'h300000},
                {HALF, ZERO, THREE5, TWO}, 4'b0000, 2};
    tbl[7]  = '{3'd7, {ONE, TWO, TWO5, THREE}, {HALF, TWO, ONE, ONE}, {4{ZERO}}, 4'b0000, 2};
    tbl[8]  = '{3'd0, {PMAX, NMAX, 22'h004001, ONE}, {PMAX, NMAX, 22'h204000, 22'h2FC000},
                {PMAX, NMAX, ZERO, ZERO}, 4'b1100, 2};
    tbl[9]  = '{3'd2, {22'h004000, ONE, 22'h2FC000, 22'h2FE000}, {22'h004000, ZERO, ZERO, TWO},
                {ZERO, ZERO, ZERO, 22'h302000}, 4'b0000, 2};
    tbl[10] = '{3'd3, {ONE, 22'h2FC000, TWO, ZERO}, {4{ZERO}}, {TWO, ZERO, ZERO, ZERO}, 4'b0000, 4};

    rst = 1'b1; i_en = 1'b0; i_rdy = 1'b1; i_opcode = '0; i_in1 = '0; i_in2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset o_output", o_output, '0);
    check("reset o_valid", W'(o_valid), W'(0));
    check("reset o_busy", W'(o_busy), W'(0));
    check("reset o_ovf", W'(o_ovf), W'(0));
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, y, ov, lat);
      check($sformatf("v%0d output", i), y, tbl[i].y);
      check($sformatf("v%0d ovf", i), W'(ov), W'(tbl[i].ovf));
      check($sformatf("v%0d latency", i), W'(lat), W'(tbl[i].lat));
    end

    // RADD busy window
    @(negedge clk);
    i_en = 1'b1; i_opcode = 3'd3; i_in1 = tbl[2].a; i_in2 = '0;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      i_en = 1'b0;
      check($sformatf("radd busy c%0d", c), W'(o_busy), W'(1));
      check($sformatf("radd valid c%0d", c), W'(o_valid), W'(c == 4));
    end
    @(negedge clk);
    check("radd busy after consume", W'(o_busy), W'(0));
    check("radd valid after consume", W'(o_valid), W'(0));

    // back-pressure with ignored requests
    i_rdy = 1'b0;
    i_en = 1'b1; i_opcode = 3'd0; i_in1 = tbl[0].a; i_in2 = tbl[0].b;
    @(posedge clk);
    @(negedge clk); i_en = 1'b0;
    @(negedge clk);
    check("bp first valid", W'(o_valid), W'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp valid k%0d", k), W'(o_valid), W'(1));
      check($sformatf("bp output k%0d", k), o_output, tbl[0].y);
      i_en = (k % 2 == 0); i_opcode = 3'd1; i_in1 = tbl[3].a; i_in2 = tbl[3].b;
    end
    @(negedge clk);
    check("bp stable before rdy", o_output, tbl[0].y);
    i_en = 1'b0; i_rdy = 1'b1;
    @(negedge clk);
    check("bp valid dropped", W'(o_valid), W'(0));
    check("bp busy dropped", W'(o_busy), W'(0));
    check("bp output held", o_output, tbl[0].y);
    @(negedge clk);
    check("bp no late accept", W'(o_busy), W'(0));

    // reset during REDUCE of a DOT with an overflowed lane
    i_en = 1'b1; i_opcode = 3'd4; i_in1 = {PMAX, ONE, ONE, ONE}; i_in2 = {TWO, ONE, ONE, ONE};
    @(posedge clk);
    @(negedge clk); i_en = 1'b0;
    @(negedge clk);
    check("pre-reset busy", W'(o_busy), W'(1));
    check("pre-reset ovf", W'(o_ovf), W'(4'b1000));
    rst = 1'b1;
    @(negedge clk);
    check("abort o_output", o_output, '0);
    check("abort o_valid", W'(o_valid), W'(0));
    check("abort o_busy", W'(o_busy), W'(0));
    check("abort o_ovf", W'(o_ovf), W'(0));
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | o_valid | o_busy;
    end
    check("abort no valid", W'(seen), W'(0));
    run_op(tbl[0].op, tbl[0].a, tbl[0].b, y, ov, lat);
    check("post-abort output", y, tbl[0].y);
    check("post-abort latency", W'(lat), W'(2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
